dut_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single cmd/adr/data bus (4 bits each) of the DUT interface among NREQ requesting masters.
- Grants one master at a time for a packet of up to MAX_BURST beats.
- Registers the winning master's beats onto the bus with a valid/ready handshake toward the slave.
- Sits between the master-side agents and the interface's slave-facing signals.

---
 rtl/dut_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_dut_bus_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered cmd/adr/data bus among NREQ masters.
// Optional stall abort is compiled in with `define DUT_ARB_TIMEOUT_EN.
module dut_bus_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [4*NREQ-1:0]       req_cmd,
  input  logic [4*NREQ-1:0]       req_adr,
  input  logic [4*NREQ-1:0]       req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         gnt,
  output logic                    bus_valid,
  output logic [3:0]              bus_cmd,
  output logic [3:0]              bus_adr,
  output logic [3:0]              bus_data,
  input  logic                    bus_ready,
  output logic [$clog2(NREQ)-1:0] bus_owner,
  output logic                    timeout_err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] winner;
  logic [CW-1:0] cnt;
  logic          hit;
  logic          free;
  logic          accept;
  logic          final_beat;
  logic          abort;

  assign free       = !bus_valid | bus_ready;
  assign accept     = (state == OWN) & gnt[owner] & req[owner] & free;
  assign final_beat = req_last[owner] | (cnt == CW'(MAX_BURST - 1));

  // First requester strictly after the pointer, wrapping around.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    winner = '0;
    hit    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!hit && req[(int'(ptr) + k) % NREQ]) begin
        winner = IW'((int'(ptr) + k) % NREQ);
        hit    = 1'b1;
      end
    end
  end

`ifdef DUT_ARB_TIMEOUT_EN
  logic [7:0] stall_cnt;
  logic       stall;

  assign stall       = bus_valid & !bus_ready;
  assign abort       = stall & (stall_cnt == 8'(TIMEOUT - 1));
  assign timeout_err = abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!stall || abort) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= IW'(NREQ - 1);
      owner <= '0;
      cnt   <= '0;
    end else if (abort) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= owner;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state <= OWN;
            owner <= winner;
            cnt   <= '0;
            gnt   <= NREQ'(1) << winner;
          end
        end
        OWN: begin
          if (!req[owner]) begin
            state <= DRAIN;
            gnt   <= '0;
            ptr   <= owner;
          end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (final_beat) begin
              state <= DRAIN;
              gnt   <= '0;
              ptr   <= owner;
            end
          end
        end
        DRAIN: begin
          if (free) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  // One-entry output slot; a new beat may replace the old one in the handshake cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_valid <= 1'b0;
      bus_cmd   <= '0;
      bus_adr   <= '0;
      bus_data  <= '0;
      bus_owner <= '0;
    end else if (abort) begin
      bus_valid <= 1'b0;
    end else if (accept) begin
      bus_valid <= 1'b1;
      bus_cmd   <= req_cmd[4*owner +: 4];
      bus_adr   <= req_adr[4*owner +: 4];
      bus_data  <= req_data[4*owner +: 4];
      bus_owner <= owner;
    end else if (bus_valid && bus_ready) begin
      bus_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dut_bus_arbiter.sv
// Self-checking bench for dut_bus_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-level round-robin model.
module tb_dut_bus_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 15;
  localparam int DEPTH     = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_cmd;
  logic [4*NREQ-1:0] req_adr;
  logic [4*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   gnt;
  logic              bus_valid;
  logic [3:0]        bus_cmd;
  logic [3:0]        bus_adr;
  logic [3:0]        bus_data;
  logic              bus_ready;
  logic [1:0]        bus_owner;
  logic              timeout_err;

  int total = 0;
  int bad   = 0;

  // Per-master packet storage used by the traffic agent and the reference model.
  logic [3:0]  mc [NREQ][DEPTH];
  logic [3:0]  ma [NREQ][DEPTH];
  logic [3:0]  md [NREQ][DEPTH];
  logic        ml [NREQ][DEPTH];
  int          mlen [NREQ];
  int          idx  [NREQ];
  logic [15:0] expq [$];

  always #5 clk = ~clk;

  dut_bus_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_cmd     (req_cmd),
    .req_adr     (req_adr),
    .req_data    (req_data),
    .req_last    (req_last),
    .gnt         (gnt),
    .bus_valid   (bus_valid),
    .bus_cmd     (bus_cmd),
    .bus_adr     (bus_adr),
    .bus_data    (bus_data),
    .bus_ready   (bus_ready),
    .bus_owner   (bus_owner),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req       = '0;
    req_last  = '0;
    req_cmd   = '0;
    req_adr   = '0;
    req_data  = '0;
    bus_ready = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic set_beat(input int i, input logic [3:0] c, input logic [3:0] a,
                          input logic [3:0] d, input logic l);
    req_cmd[4*i +: 4]  = c;
    req_adr[4*i +: 4]  = a;
    req_data[4*i +: 4] = d;
    req_last[i]        = l;
  endtask

  task automatic clear_packets();
    for (int i = 0; i < NREQ; i++) mlen[i] = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus_valid); end
    total++; if ({bus_cmd, bus_adr, bus_data} !== 12'h0) begin
      bad++; $display("FAIL reset_fields: got %h want 000", {bus_cmd, bus_adr, bus_data}); end
    total++; if (bus_owner !== 2'd0) begin bad++; $display("FAIL reset_owner: got %0d want 0", bus_owner); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end

    // Start a burst, let a beat sit in the slot, then reset between clock edges.
    req[0] = 1'b1;
    set_beat(0, 4'd1, 4'd2, 4'd3, 1'b0);
    bus_ready = 1'b0;
    tick();
    tick();
    total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL midburst_valid: got %b want 1", bus_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({gnt, bus_valid, bus_owner, timeout_err} !== '0) begin
      bad++; $display("FAIL async_reset_ctrl: got gnt=%b valid=%b owner=%0d terr=%b want all 0",
                      gnt, bus_valid, bus_owner, timeout_err); end
    total++; if ({bus_cmd, bus_adr, bus_data} !== 12'h0) begin
      bad++; $display("FAIL async_reset_fields: got %h want 000", {bus_cmd, bus_adr, bus_data}); end
    req       = '0;
    bus_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    req[2] = 1'b1;
    set_beat(2, 4'd5, 4'd5, 4'd5, 1'b1);
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL reset_first_gnt: got %b want 0100", gnt); end
    req = '0;
    repeat (4) tick();
  endtask

  task automatic test_single();
    do_reset();
    bus_ready = 1'b1;
    req[0] = 1'b1;
    set_beat(0, 4'd3, 4'd5, 4'd9, 1'b0);
    tick();  // cycle 1
    total++; if (gnt !== 4'b0001 || bus_valid !== 1'b0) begin
      bad++; $display("FAIL single_c1: got gnt=%b valid=%b want 0001/0", gnt, bus_valid); end
    tick();  // cycle 2
    total++; if (bus_valid !== 1'b1 || {bus_cmd, bus_adr, bus_data} !== 12'h359 || bus_owner !== 2'd0) begin
      bad++; $display("FAIL single_beat1: got v=%b f=%h o=%0d want 1/359/0",
                      bus_valid, {bus_cmd, bus_adr, bus_data}, bus_owner); end
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_c2_gnt: got %b want 0001", gnt); end
    set_beat(0, 4'd4, 4'd6, 4'd10, 1'b1);
    tick();  // cycle 3
    total++; if (bus_valid !== 1'b1 || {bus_cmd, bus_adr, bus_data} !== 12'h46a || bus_owner !== 2'd0) begin
      bad++; $display("FAIL single_beat2: got v=%b f=%h o=%0d want 1/46a/0",
                      bus_valid, {bus_cmd, bus_adr, bus_data}, bus_owner); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_c3_gnt: got %b want 0000", gnt); end
    req      = '0;
    req_last = '0;
    tick();  // cycle 4
    total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL single_c4_valid: got %b want 0", bus_valid); end
    // A fresh request must be seen as soon as the arbiter is idle again.
    req[1] = 1'b1;
    set_beat(1, 4'd1, 4'd1, 4'd1, 1'b1);
    tick();  // cycle 5
    if (gnt !== 4'b0010) tick();  // cycle 6
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL single_idle_regrant: got %b want 0010", gnt); end
    req = '0;
    repeat (4) tick();
  endtask

  task automatic test_fairness();
    int          got;
    int          w;
    int          p;
    logic [3:0]  prev;
    do_reset();
    req       = '1;
    bus_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_beat(i, 4'(i), 4'(i + 1), 4'(i + 2), 1'b1);
    got  = 0;
    p    = NREQ - 1;
    prev = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      tick();
      if (gnt !== '0 && gnt !== prev) begin
        w = (p + 1) % NREQ;  // everybody requests, so the next index always wins
        total++; if (gnt !== 4'(1 << w)) begin
          bad++; $display("FAIL fairness_grant%0d: got %b want %b", got, gnt, 4'(1 << w)); end
        p = w;
        got++;
      end
      prev = gnt;
    end
    total++; if (got != 6) begin bad++; $display("FAIL fairness_count: got %0d grants want 6", got); end
    req = '0;
    repeat (4) tick();
  endtask

  // Transaction-level model: expected beat stream from round-robin order and burst rules.
  task automatic build_expected();
    int rem [NREQ];
    int pos [NREQ];
    int p;
    int w;
    int n;
    expq.delete();
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = mlen[i];
      pos[i] = 0;
    end
    p = NREQ - 1;
    forever begin
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && rem[(p + k) % NREQ] > 0) w = (p + k) % NREQ;
      if (w < 0) break;
      n = 0;
      do begin
        expq.push_back({4'(w), mc[w][pos[w]], ma[w][pos[w]], md[w][pos[w]]});
        n++;
        pos[w]++;
        rem[w]--;
      end while (!ml[w][pos[w]-1] && n < MAX_BURST && rem[w] > 0);
      p = w;
    end
  endtask

  // mode 0: always ready; 1: random ready; 2: five stall cycles on the first beat.
  task automatic run_traffic(input string name, input int mode);
    int          exp_n;
    int          hs;
    int          hold;
    int          zero_run;
    bit          done;
    logic        pv;
    logic [15:0] pf;
    logic [15:0] obs;
    logic [15:0] e;
    build_expected();
    exp_n    = expq.size();
    hs       = 0;
    hold     = 0;
    zero_run = 0;
    pv       = 1'b0;
    pf       = '0;
    for (int i = 0; i < NREQ; i++) idx[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (idx[i] < mlen[i]) begin
          req[i] = 1'b1;
          set_beat(i, mc[i][idx[i]], ma[i][idx[i]], md[i][idx[i]], ml[i][idx[i]]);
        end else begin
          req[i]      = 1'b0;
          req_last[i] = 1'b0;
        end
      end
      case (mode)
        1: begin
          bus_ready = (zero_run >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
          zero_run  = bus_ready ? 0 : zero_run + 1;
        end
        2: begin
          bus_ready = !(bus_valid && hold < 5);
          if (bus_valid && hold < 5) hold++;
        end
        default: bus_ready = 1'b1;
      endcase
      obs = {2'b00, bus_owner, bus_cmd, bus_adr, bus_data};
      if (pv) begin
        total++; if (bus_valid !== 1'b1 || obs !== pf) begin
          bad++; $display("FAIL %s_stable: got v=%b beat=%h want 1/%h", name, bus_valid, obs, pf); end
      end
      pv = bus_valid & !bus_ready;
      pf = obs;
      if (bus_valid && bus_ready) begin
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL %s_extra_beat: got %h want none", name, obs);
        end else begin
          e = expq.pop_front();
          if (obs !== e) begin bad++; $display("FAIL %s_beat%0d: got %h want %h", name, hs, obs, e); end
        end
        hs++;
      end
      for (int i = 0; i < NREQ; i++)
        if (gnt[i] && req[i] && (!bus_valid || bus_ready)) idx[i]++;
      done = (expq.size() == 0);
      for (int i = 0; i < NREQ; i++) if (idx[i] < mlen[i]) done = 1'b0;
      if (done) break;
    end
    total++; if (expq.size() != 0 || hs != exp_n) begin
      bad++; $display("FAIL %s_count: got %0d beats want %0d", name, hs, exp_n); end
    req       = '0;
    req_last  = '0;
    bus_ready = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_burst_cap();
    clear_packets();
    mlen[1] = 6;
    for (int k = 0; k < 6; k++) begin
      mc[1][k] = 4'(k); ma[1][k] = 4'(k + 3); md[1][k] = 4'(15 - k); ml[1][k] = 1'b0;
    end
    mlen[2] = 1;
    mc[2][0] = 4'hc; ma[2][0] = 4'hd; md[2][0] = 4'he; ml[2][0] = 1'b1;
    do_reset();
    run_traffic("burst_cap", 0);
  endtask

  task automatic test_backpressure();
    clear_packets();
    mlen[3] = 4;
    for (int k = 0; k < 4; k++) begin
      mc[3][k] = 4'(k + 1); ma[3][k] = 4'(k + 5); md[3][k] = 4'(k + 9); ml[3][k] = (k == 3);
    end
    do_reset();
    run_traffic("backpressure", 2);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        mlen[i] = $urandom_range(0, 12);
        for (int k = 0; k < DEPTH; k++) begin
          mc[i][k] = 4'($urandom_range(0, 15));
          ma[i][k] = 4'($urandom_range(0, 15));
          md[i][k] = 4'($urandom_range(0, 15));
          ml[i][k] = ($urandom_range(0, 2) == 0);
        end
      end
      do_reset();
      run_traffic($sformatf("random%0d", r), (r == 0) ? 0 : 1);
    end
  endtask

  task automatic test_stall();
    int s;
    do_reset();
    bus_ready = 1'b0;
    req[0] = 1'b1;
    set_beat(0, 4'd7, 4'd7, 4'd7, 1'b0);
    req[1] = 1'b1;
    set_beat(1, 4'd8, 4'd8, 4'd8, 1'b1);
    s = 0;
    while (bus_valid !== 1'b1 && s < 10) begin tick(); s++; end
    total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL stall_start: got valid=%b want 1", bus_valid); end
`ifdef DUT_ARB_TIMEOUT_EN
    s = 1;  // this cycle is the first stall cycle
    while (timeout_err !== 1'b1 && s < 40) begin tick(); s++; end
    total++; if (s != TIMEOUT) begin bad++; $display("FAIL timeout_cycle: got stall %0d want %0d", s, TIMEOUT); end
    tick();
    total++; if (bus_valid !== 1'b0 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL timeout_after: got v=%b terr=%b want 0/0", bus_valid, timeout_err); end
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL timeout_regrant: got %b want 0010", gnt); end
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      total++; if (bus_valid !== 1'b1 || timeout_err !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d: got v=%b terr=%b want 1/0", c, bus_valid, timeout_err); end
    end
`endif
    req       = '0;
    bus_ready = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_burst_cap();
    test_backpressure();
    test_random();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
